// File: rtl/cp0_except_if.sv
// cp0_except_if: pipeline-to-CP0 signal bundle.
// The master modport is the pipeline side and the slave modport is the CP0 side.
interface cp0_except_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_ds;
    logic [5:0]  mem_exc;
    logic [31:0] mem_badaddr;
    logic        mem_eret;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [6:0]  o_except;
    logic [31:0] o_epc;
    logic        o_eret;
    logic        timer_int;

    modport master (
        output mem_valid, mem_pc, mem_in_ds, mem_exc, mem_badaddr, mem_eret, hw_int,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, o_except, o_epc, o_eret, timer_int
    );

    modport slave (
        input  mem_valid, mem_pc, mem_in_ds, mem_exc, mem_badaddr, mem_eret, hw_int,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, o_except, o_epc, o_eret, timer_int
    );
endinterface

// File: rtl/cp0_except.sv
// cp0_except: MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC).
// Also provides MEM-stage exception prioritisation and commit.
module cp0_except (
    input  logic        clk,
    input  logic        reset,
    cp0_except_if.slave bus
);
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic        r_cause_ti;
    logic [5:0]  r_cause_iphw;
    logic [1:0]  r_cause_ipsw;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;

    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_int;
    logic [6:0]  w_raw;
    logic [6:0]  w_except;
    logic        w_commit;
    logic        w_eret;
    logic        w_load_epc;
    logic [4:0]  w_code;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_status = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, r_cause_ti, 14'd0, r_cause_iphw, r_cause_ipsw, 1'b0, r_cause_exc, 2'b00};

    assign w_int    = r_status_ie & ~r_status_exl & |({r_cause_iphw, r_cause_ipsw} & r_status_im);
    assign w_raw    = bus.mem_valid ? {bus.mem_exc, w_int} : 7'd0;
    // Isolating the lowest set bit selects the highest-priority cause.
    assign w_except = w_raw & (~w_raw + 7'd1);
    assign w_commit = |w_except;
    assign w_eret   = bus.mem_valid & bus.mem_eret & ~w_commit;
    assign w_load_epc = w_commit & ~r_status_exl;
    assign w_code   = w_except[0] ? 5'd0 : w_except[1] ? 5'd4 : w_except[2] ? 5'd5 :
                      w_except[3] ? 5'd8 : w_except[4] ? 5'd9 : w_except[5] ? 5'd10 : 5'd12;

    assign w_wr_status  = bus.cp0_we & (bus.cp0_waddr == 5'd12);
    assign w_wr_cause   = bus.cp0_we & (bus.cp0_waddr == 5'd13);
    assign w_wr_epc     = bus.cp0_we & (bus.cp0_waddr == 5'd14);
    assign w_wr_count   = bus.cp0_we & (bus.cp0_waddr == 5'd9);
    assign w_wr_compare = bus.cp0_we & (bus.cp0_waddr == 5'd11);

    assign bus.o_except  = w_except;
    assign bus.o_eret    = w_eret;
    assign bus.o_epc     = w_wr_epc ? bus.cp0_wdata : r_epc;
    assign bus.timer_int = r_cause_ti;
    assign bus.cp0_rdata = (bus.cp0_raddr == 5'd8)  ? r_badvaddr :
                           (bus.cp0_raddr == 5'd9)  ? r_count    :
                           (bus.cp0_raddr == 5'd11) ? r_compare  :
                           (bus.cp0_raddr == 5'd12) ? w_status   :
                           (bus.cp0_raddr == 5'd13) ? w_cause    :
                           (bus.cp0_raddr == 5'd14) ? r_epc      : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status_im  <= 8'd0;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
            r_cause_bd   <= 1'b0;
            r_cause_ti   <= 1'b0;
            r_cause_iphw <= 6'd0;
            r_cause_ipsw <= 2'd0;
            r_cause_exc  <= 5'd0;
            r_epc        <= 32'd0;
            r_badvaddr   <= 32'd0;
            r_count      <= 32'd0;
            r_compare    <= 32'd0;
            r_tick       <= 1'b0;
        end else begin
            r_tick       <= ~r_tick;
            r_count      <= w_wr_count ? bus.cp0_wdata : r_count + {31'd0, r_tick};
            r_compare    <= w_wr_compare ? bus.cp0_wdata : r_compare;
            r_cause_ti   <= ~w_wr_compare & (r_cause_ti | (r_count == r_compare));
            r_cause_iphw <= {bus.hw_int[5] | r_cause_ti, bus.hw_int[4:0]};
            r_cause_ipsw <= w_wr_cause ? bus.cp0_wdata[9:8] : r_cause_ipsw;
            r_status_im  <= w_wr_status ? bus.cp0_wdata[15:8] : r_status_im;
            r_status_ie  <= w_wr_status ? bus.cp0_wdata[0] : r_status_ie;
            // Commit/ERET take priority over an MTC0 to the same field.
            r_status_exl <= w_commit ? 1'b1 : w_eret ? 1'b0 : w_wr_status ? bus.cp0_wdata[1] : r_status_exl;
            r_cause_exc  <= w_commit ? w_code : r_cause_exc;
            r_cause_bd   <= w_load_epc ? bus.mem_in_ds : r_cause_bd;
            r_epc        <= w_load_epc ? (bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc) :
                            w_wr_epc ? bus.cp0_wdata : r_epc;
            r_badvaddr   <= (w_except[1] | w_except[2]) ? bus.mem_badaddr : r_badvaddr;
        end
    end
endmodule

// File: tb/tb_cp0_except.sv
// tb_cp0_except: directed scoreboard bench for cp0_except.
// Expected values are queued as each step is driven and popped when the DUT output is sampled.
module tb_cp0_except;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_q[$];

    cp0_except_if bus ();
    cp0_except dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string tag);
        push(v);
        bus.cp0_raddr = a;
        #1;
        chk(tag, bus.cp0_rdata);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        tick();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic idle_mem();
        bus.mem_valid = 1'b0;
        bus.mem_exc   = 6'd0;
        bus.mem_eret  = 1'b0;
        bus.cp0_we    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.mem_pc = 32'd0;
        bus.mem_in_ds = 1'b0;
        bus.mem_badaddr = 32'd0;
        bus.hw_int = 6'd0;
        bus.cp0_waddr = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.cp0_raddr = 5'd0;
        idle_mem();
        tick();
        tick();
        rd(5'd12, 32'h0040_0000, "rst_status");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        push(32'h0); chk("rst_except", {25'd0, bus.o_except});
        push(32'h0); chk("rst_eret", {31'd0, bus.o_eret});
        rd(5'd10, 32'h0, "unmapped_reg");
        reset = 1'b0;
        rd(5'd13, 32'h0, "cause_after_rst");
        for (int i = 0; i < 20; i++) tick();
        rd(5'd9, 32'd10, "count_20cyc");
        push(32'h1); chk("ti_cnt_eq_cmp", {31'd0, bus.timer_int});
        rd(5'd13, 32'h4000_8000, "cause_ti_ip7");

        wr(5'd11, 32'h0000_1000);
        tick();
        push(32'h0); chk("ti_clr", {31'd0, bus.timer_int});
        rd(5'd13, 32'h0, "cause_clr");

        // Sys in a delay slot, with a concurrent Status write of EXL=0
        bus.mem_valid = 1'b1;
        bus.mem_exc   = 6'h04;
        bus.mem_pc    = 32'hBFC0_1000;
        bus.mem_in_ds = 1'b1;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = 32'h0000_0300;
        push(32'h08); #1; chk("sys_except", {25'd0, bus.o_except});
        tick();
        idle_mem();
        rd(5'd14, 32'hBFC0_0FFC, "sys_epc");
        rd(5'd13, 32'h8000_0020, "sys_cause");
        rd(5'd12, 32'h0040_0302, "sys_status_mix");

        bus.mem_valid   = 1'b1;
        bus.mem_exc     = 6'h03;
        bus.mem_badaddr = 32'h0000_0003;
        bus.mem_pc      = 32'h1234_5678;
        bus.mem_in_ds   = 1'b0;
        push(32'h02); #1; chk("adel_prio", {25'd0, bus.o_except});
        tick();
        idle_mem();
        rd(5'd13, 32'h8000_0010, "adel_cause");
        rd(5'd8, 32'h0000_0003, "badvaddr");
        rd(5'd14, 32'hBFC0_0FFC, "epc_kept_exl");

        bus.mem_valid = 1'b1;
        bus.mem_eret  = 1'b1;
        bus.mem_exc   = 6'h10;
        push(32'h20); #1; chk("ri_except", {25'd0, bus.o_except});
        push(32'h0); chk("eret_blocked", {31'd0, bus.o_eret});
        bus.mem_exc   = 6'h00;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h8000_1234;
        push(32'h1); #1; chk("eret", {31'd0, bus.o_eret});
        push(32'h8000_1234); chk("epc_bypass", bus.o_epc);
        rd(5'd14, 32'hBFC0_0FFC, "epc_no_rd_bypass");
        tick();
        idle_mem();
        rd(5'd12, 32'h0040_0300, "eret_exl_clr");
        rd(5'd14, 32'h8000_1234, "epc_written");

        wr(5'd12, 32'h0040_FF01);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        for (int i = 0; i < 40 && !bus.timer_int; i++) tick();
        push(32'h1); chk("ti_wait", {31'd0, bus.timer_int});
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_exc   = 6'h20;
        bus.mem_pc    = 32'h0040_0100;
        bus.mem_in_ds = 1'b0;
        push(32'h01); #1; chk("int_over_ov", {25'd0, bus.o_except});
        tick();
        push(32'h40); chk("ov_after_exl", {25'd0, bus.o_except});
        bus.mem_valid = 1'b0;
        push(32'h0); #1; chk("invalid_zero", {25'd0, bus.o_except});
        idle_mem();
        rd(5'd14, 32'h0040_0100, "int_epc");
        rd(5'd13, 32'h4000_8000, "int_cause");
        rd(5'd12, 32'h0040_FF03, "int_status");
        wr(5'd11, 32'h0000_1000);
        push(32'h0); chk("ti_cmp_write", {31'd0, bus.timer_int});

        wr(5'd9, 32'hFFFF_FFFF);
        tick();
        tick();
        rd(5'd9, 32'h0, "count_wrap");

        bus.mem_valid = 1'b1;
        bus.mem_exc   = 6'h01;
        reset = 1'b1;
        push(32'h02); #1; chk("adel_pre_rst", {25'd0, bus.o_except});
        tick();
        push(32'h02); chk("except_in_rst", {25'd0, bus.o_except});
        idle_mem();
        reset = 1'b0;
        rd(5'd12, 32'h0040_0000, "rst2_status");
        rd(5'd13, 32'h0, "rst2_cause");
        rd(5'd14, 32'h0, "rst2_epc");
        rd(5'd8, 32'h0, "rst2_badvaddr");
        rd(5'd9, 32'h0, "rst2_count");
        push(32'h0); chk("rst2_except", {25'd0, bus.o_except});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
